// File: rtl/spi_acl_if.sv
// SPI mode-3 link between the ACL master and the sensor responder.
interface spi_acl_if;
  logic sclk;
  logic ss;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, ss, mosi, input miso, miso_oe);
  modport slave  (input sclk, ss, mosi, output miso, miso_oe);
endinterface

// File: rtl/spi_acl_responder.sv
// ADXL345-style SPI mode-3 slave emulating the PmodACL; SCLK/SS/MOSI oversampled on clk.
// Optional truncation error reporting (err_pulse/err_cnt) with `define SPI_RESP_ERR_EN.
module spi_acl_responder #(
  parameter logic [7:0]  DEVID_VAL   = 8'hE5,
  parameter logic [7:0]  BW_RATE_RST = 8'h0A,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  spi_acl_if.slave    spi,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  output logic        snapshot,
  output logic        wr_strobe,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        measure
`ifdef SPI_RESP_ERR_EN
  ,
  output logic        err_pulse,
  output logic [7:0]  err_cnt
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, ss_sync_q, ss_sync_d, mosi_sync_q, mosi_sync_d;
  logic sclk_prev_q, ss_prev_q, ss_act_q, ss_act_d;
  state_t state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d, tx_q, tx_d;
  logic        rw_q, rw_d, mb_q, mb_d, reload_q, reload_d;
  logic [5:0]  addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        miso_q, miso_d, oe_q, oe_d, snapshot_q, snapshot_d;
  logic        wr_strobe_q, wr_strobe_d, busy_q, busy_d;
  logic [7:0]  bw_rate_q, bw_rate_d, power_ctl_q, power_ctl_d, data_fmt_q, data_fmt_d;
  logic [15:0] shx_q, shx_d, shy_q, shy_d, shz_q, shz_d;
`ifdef SPI_RESP_ERR_EN
  logic        err_pulse_q, err_pulse_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
`endif

  logic sclk_cur, ss_cur, mosi_cur, sclk_rise, sclk_fall, ss_rise;
  logic [7:0] rx_byte, rd_data, nxt;
  logic [5:0] rd_addr;

  assign sclk_cur  = sclk_sync_q[SYNC_STAGES-1];
  assign ss_cur    = ss_sync_q[SYNC_STAGES-1];
  assign mosi_cur  = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_cur & ~sclk_prev_q;
  assign sclk_fall = ~sclk_cur & sclk_prev_q;
  assign ss_rise   = ss_act_q & ss_cur;
  assign rx_byte   = {rx_q[6:0], mosi_cur};

  always_comb begin
    rd_addr = (state_q == ST_CMD) ? rx_byte[5:0] : addr_q;
    rd_data = '0;
    case (rd_addr)
      6'h00:   rd_data = DEVID_VAL;
      6'h2C:   rd_data = bw_rate_q;
      6'h2D:   rd_data = power_ctl_q;
      6'h31:   rd_data = data_fmt_q;
      6'h32:   rd_data = measure ? shx_q[7:0]  : '0;
      6'h33:   rd_data = measure ? shx_q[15:8] : '0;
      6'h34:   rd_data = measure ? shy_q[7:0]  : '0;
      6'h35:   rd_data = measure ? shy_q[15:8] : '0;
      6'h36:   rd_data = measure ? shz_q[7:0]  : '0;
      6'h37:   rd_data = measure ? shz_q[15:8] : '0;
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], spi.ss};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
    // Select must be seen low on two consecutive clocks before a transaction opens.
    ss_act_d    = ss_act_q ? ~ss_cur : (~ss_cur & ~ss_prev_q);
    oe_d        = ss_act_d;
    state_d = state_q;   bit_cnt_d = bit_cnt_q; rx_d = rx_q;     tx_d = tx_q;
    rw_d = rw_q;         mb_d = mb_q;           addr_d = addr_q; reload_d = reload_q;
    miso_d = miso_q;     wr_addr_d = wr_addr_q; wr_data_d = wr_data_q;
    bw_rate_d = bw_rate_q; power_ctl_d = power_ctl_q; data_fmt_d = data_fmt_q;
    shx_d = shx_q;       shy_d = shy_q;         shz_d = shz_q;
    snapshot_d = 1'b0;   wr_strobe_d = 1'b0;    nxt = rd_data;
`ifdef SPI_RESP_ERR_EN
    err_pulse_d = ss_rise & ((state_q == ST_CMD) | (bit_cnt_q != 3'd0));
    err_cnt_d   = (err_pulse_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
`endif
    if (ss_rise) begin
      state_d = ST_IDLE; bit_cnt_d = '0; reload_d = 1'b0; miso_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (ss_act_d) begin
          state_d = ST_CMD; bit_cnt_d = '0; snapshot_d = 1'b1;
          shx_d = sample_x; shy_d = sample_y; shz_d = sample_z;
        end
        ST_CMD: if (sclk_rise) begin
          rx_d = rx_byte; bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_DATA; rw_d = rx_byte[7]; mb_d = rx_byte[6];
            addr_d = rx_byte[5:0]; tx_d = rd_data; reload_d = 1'b0;
          end
        end
        ST_DATA: begin
          if (sclk_rise) begin
            rx_d = rx_byte; bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (!rw_q) begin
                wr_strobe_d = 1'b1; wr_addr_d = addr_q; wr_data_d = rx_byte;
                case (addr_q)
                  6'h2C:   bw_rate_d   = rx_byte;
                  6'h2D:   power_ctl_d = rx_byte;
                  6'h31:   data_fmt_d  = rx_byte;
                  default: ;
                endcase
              end else begin
                reload_d = 1'b1;
              end
              if (mb_q) addr_d = addr_q + 6'd1;
            end
          end else if (sclk_fall && rw_q) begin
            // Next-address byte is fetched on the falling edge that emits its MSB.
            if (!reload_q) nxt = tx_q;
            miso_d = nxt[7]; tx_d = {nxt[6:0], 1'b0}; reload_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '1; ss_sync_q <= '1; mosi_sync_q <= '0;
      sclk_prev_q <= 1'b1; ss_prev_q <= 1'b1; ss_act_q <= 1'b0;
      state_q <= ST_IDLE; bit_cnt_q <= '0; rx_q <= '0; tx_q <= '0;
      rw_q <= 1'b0; mb_q <= 1'b0; addr_q <= '0; reload_q <= 1'b0;
      miso_q <= 1'b1; oe_q <= 1'b0; snapshot_q <= 1'b0; wr_strobe_q <= 1'b0;
      wr_addr_q <= '0; wr_data_q <= '0; busy_q <= 1'b0;
      bw_rate_q <= BW_RATE_RST; power_ctl_q <= '0; data_fmt_q <= '0;
      shx_q <= '0; shy_q <= '0; shz_q <= '0;
`ifdef SPI_RESP_ERR_EN
      err_pulse_q <= 1'b0; err_cnt_q <= '0;
`endif
    end else begin
      sclk_sync_q <= sclk_sync_d; ss_sync_q <= ss_sync_d; mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_cur; ss_prev_q <= ss_cur; ss_act_q <= ss_act_d;
      state_q <= state_d; bit_cnt_q <= bit_cnt_d; rx_q <= rx_d; tx_q <= tx_d;
      rw_q <= rw_d; mb_q <= mb_d; addr_q <= addr_d; reload_q <= reload_d;
      miso_q <= miso_d; oe_q <= oe_d; snapshot_q <= snapshot_d; wr_strobe_q <= wr_strobe_d;
      wr_addr_q <= wr_addr_d; wr_data_q <= wr_data_d; busy_q <= busy_d;
      bw_rate_q <= bw_rate_d; power_ctl_q <= power_ctl_d; data_fmt_q <= data_fmt_d;
      shx_q <= shx_d; shy_q <= shy_d; shz_q <= shz_d;
`ifdef SPI_RESP_ERR_EN
      err_pulse_q <= err_pulse_d; err_cnt_q <= err_cnt_d;
`endif
    end
  end

  assign spi.miso    = miso_q;
  assign spi.miso_oe = oe_q;
  assign snapshot    = snapshot_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
  assign measure     = power_ctl_q[3];
`ifdef SPI_RESP_ERR_EN
  assign err_pulse   = err_pulse_q;
  assign err_cnt     = err_cnt_q;
`endif

endmodule
